// File: rtl/prod_accumulator.sv
// prod_accumulator: sums each group of N unsigned 16-bit products from the
// multiplier and presents every completed group sum on a registered
// valid/ready port. Sums wrap modulo 2^ACC_W; ovf flags a group that wrapped.
module prod_accumulator #(
    parameter int unsigned N     = 4,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [15:0]      p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic {StAccum, StHold} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             ovf_acc_q, ovf_acc_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W:0]   p_ext;
    logic [ACC_W:0]   sum;
    logic             first_elem;
    logic             ovf_sum;
    logic             accept;

    // Acceptance depends only on state and clr, never on p_valid or out_ready.
    assign p_ready   = (state_q == StAccum) && !clr;
    assign accept    = p_valid && p_ready;
    assign acc_out   = acc_out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;

    // Running sum; the first element of a group starts from zero so stale
    // accumulator contents never need an explicit clear.
    always_comb begin
        first_elem = (cnt_q == '0);
        p_ext      = {{(ACC_W - 15){1'b0}}, p_in};
        sum        = (first_elem ? '0 : {1'b0, acc_q}) + p_ext;
        ovf_sum    = (first_elem ? 1'b0 : ovf_acc_q) | sum[ACC_W];
    end

    // Next-state logic for the group counter, accumulator and output register.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        acc_out_d   = acc_out_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StAccum: begin
                if (clr) begin
                    cnt_d     = '0;
                    ovf_acc_d = 1'b0;
                end else if (accept) begin
                    acc_d     = sum[ACC_W-1:0];
                    ovf_acc_d = ovf_sum;
                    if (cnt_q == CntLast) begin
                        acc_out_d   = sum[ACC_W-1:0];
                        ovf_d       = ovf_sum;
                        out_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = StHold;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StHold: begin
                // clr is ignored here: it aborts only a partial group.
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StAccum;
                end
            end
            default: state_d = StAccum;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StAccum;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            acc_out_q   <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            acc_out_q   <= acc_out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
